// File: rtl/imm_pkg.sv
// Purpose : shared types and opcode constants for the decode-stage immediate path.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: imm_src_t (ImmSrc encoding), entry_t (one buffered decode result),
//           ENTRY_RESET (value a buffer entry takes under reset), RV32 major opcodes.
package imm_pkg;

   typedef enum logic [2:0] {
      IMM_I    = 3'b000,
      IMM_S    = 3'b001,
      IMM_B    = 3'b010,
      IMM_J    = 3'b011,
      IMM_U    = 3'b100,
      IMM_CSRI = 3'b101,
      IMM_NONE = 3'b110,
      IMM_ILL  = 3'b111
   } imm_src_t;

   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] SYSTEM = 7'b1110011;
   localparam logic [6:0] OP     = 7'b0110011;

   // One fully decoded instruction as held in the main or skid entry.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      imm_src_t    imm_src;
      logic [31:0] imm;
      logic        illegal;
   } entry_t;

   localparam entry_t ENTRY_RESET = '{
      instr   : 32'h0,
      pc      : 32'h0,
      imm_src : IMM_NONE,
      imm     : 32'h0,
      illegal : 1'b0
   };

endpackage

// File: rtl/imm_src_decode.sv
// Purpose : map opcode (and funct3 MSB for SYSTEM) to the ImmSrc selector and illegal flag.
// Latency : combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports   : opcode_i  - instr[6:0]
//           f3_msb_i  - instr[14], separates CSR-immediate forms from CSR-register forms
//           imm_src_o - selected immediate format
//           illegal_o - opcode not recognised
module imm_src_decode
   import imm_pkg::*;
(
   input  logic [6:0] opcode_i,
   input  logic       f3_msb_i,
   output imm_src_t   imm_src_o,
   output logic       illegal_o
);

   always_comb begin
      imm_src_o = IMM_ILL;
      case (opcode_i)
         OP_IMM, LOAD, JALR: imm_src_o = IMM_I;
         STORE:              imm_src_o = IMM_S;
         BRANCH:             imm_src_o = IMM_B;
         JAL:                imm_src_o = IMM_J;
         LUI, AUIPC:         imm_src_o = IMM_U;
         // csrr*i carry a 5-bit zimm in rs1; csrr* / ecall / ebreak use the I field.
         SYSTEM:             imm_src_o = f3_msb_i ? IMM_CSRI : IMM_I;
         OP:                 imm_src_o = IMM_NONE;
         default:            imm_src_o = IMM_ILL;
      endcase
   end

   assign illegal_o = (imm_src_o == IMM_ILL);

endmodule

// File: rtl/imm_decode_stage.sv
// Purpose : decode-side immediate stage; decodes ImmSrc, expands the immediate, buffers result.
// Latency : 1 cycle from accepted input to out_valid.
// Backpressure: 2-entry skid (main + skid); in_ready is !skid_valid, straight from a flop.
// Ports   : clk, rst_n (async active-low), flush (sync kill of both entries)
//           in_valid/in_ready/in_instr/in_pc      - fetch side
//           out_valid/out_ready/out_instr/out_pc  - execute side, driven by the main entry
//           out_imm_src/out_imm/out_illegal       - decode results travelling with the entry
module imm_decode_stage
   import imm_pkg::*;
#(
   parameter int XLEN = 32
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc,
   output imm_src_t        out_imm_src,
   output logic [XLEN-1:0] out_imm,
   output logic            out_illegal
);

   imm_src_t    dec_src;
   logic        dec_illegal;
   logic [31:0] dec_imm;
   entry_t      in_entry;

   entry_t main_q, main_d;
   entry_t skid_q, skid_d;
   logic   main_vld_q, main_vld_d;
   logic   skid_vld_q, skid_vld_d;

   logic accept;
   logic pop;

   imm_src_decode u_src_decode (
      .opcode_i  (in_instr[6:0]),
      .f3_msb_i  (in_instr[14]),
      .imm_src_o (dec_src),
      .illegal_o (dec_illegal)
   );

   // Immediate expansion; none/illegal yield zero so out_imm is always defined.
   always_comb begin
      dec_imm = 32'h0;
      case (dec_src)
         IMM_I:    dec_imm = {{20{in_instr[31]}}, in_instr[31:20]};
         IMM_S:    dec_imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         IMM_B:    dec_imm = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                              in_instr[11:8], 1'b0};
         IMM_J:    dec_imm = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                              in_instr[30:21], 1'b0};
         IMM_U:    dec_imm = {in_instr[31:12], 12'h000};
         IMM_CSRI: dec_imm = {27'h0, in_instr[19:15]};
         default:  dec_imm = 32'h0;
      endcase
   end

   always_comb begin
      in_entry         = ENTRY_RESET;
      in_entry.instr   = in_instr;
      in_entry.pc      = in_pc;
      in_entry.imm_src = dec_src;
      in_entry.imm     = dec_imm;
      in_entry.illegal = dec_illegal;
   end

   assign in_ready  = !skid_vld_q;
   assign accept    = in_valid && in_ready;
   assign pop       = main_vld_q && out_ready;

   // Skid control. The skid only fills while main is stalled, so skid valid
   // implies main valid; when skid is valid in_ready is low, hence no accept
   // can coincide with the skid-to-main move.
   always_comb begin
      main_d     = main_q;
      main_vld_d = main_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      if (flush) begin
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (!main_vld_q || pop) begin
         if (skid_vld_q) begin
            main_d     = skid_q;
            main_vld_d = 1'b1;
            skid_vld_d = 1'b0;
         end else begin
            main_vld_d = accept;
            if (accept) begin
               main_d = in_entry;
            end
         end
      end else if (accept) begin
         skid_d     = in_entry;
         skid_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q     <= ENTRY_RESET;
         skid_q     <= ENTRY_RESET;
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
      end
   end

   assign out_valid   = main_vld_q;
   assign out_instr   = main_q.instr;
   assign out_pc      = main_q.pc;
   assign out_imm_src = main_q.imm_src;
   assign out_imm     = main_q.imm;
   assign out_illegal = main_q.illegal;

endmodule
